// File: rtl/spi_slave_pkg.sv
// Shared widths and FSM state type for the SPI slave register front end.
package spi_slave_pkg;

    localparam int DEFAULT_ADDR_LEN = 8;
    localparam int DEFAULT_WAIT_LEN = 2;
    localparam int DEFAULT_WORD_LEN = 16;
    localparam int FRAME_LEN = 1 + DEFAULT_ADDR_LEN + DEFAULT_WAIT_LEN + DEFAULT_WORD_LEN;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WAIT,
        ST_DATA,
        ST_DONE
    } spi_state_e;

endpackage

// File: rtl/spi_slave_sync.sv
// Brings SCLK, SS and MOSI into the system clock domain and flags SCLK edges.
module spi_slave_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sclk,
    input  logic ss,
    input  logic mosi,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic ss_active,
    output logic mosi_s
);

    logic [SYNC_STAGES-1:0] sclk_q;
    logic [SYNC_STAGES-1:0] ss_q;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic                   sclk_d;

    // SS resets to its inactive (high) level so no frame starts out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_q <= '0;
            ss_q   <= '1;
            mosi_q <= '0;
            sclk_d <= 1'b0;
        end else begin
            sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk};
            ss_q   <= {ss_q[SYNC_STAGES-2:0], ss};
            mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
            sclk_d <= sclk_q[SYNC_STAGES-1];
        end
    end

    assign sclk_rise = sclk_q[SYNC_STAGES-1] & ~sclk_d;
    assign sclk_fall = ~sclk_q[SYNC_STAGES-1] & sclk_d;
    assign ss_active = ~ss_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_slave_top.sv
// SPI mode-0 slave: decodes {rw, addr, wait, data} frames into register
// read/write strobes and shifts read data back out on MISO.
module spi_slave_top
    import spi_slave_pkg::*;
#(
    parameter int ADDR_LEN    = DEFAULT_ADDR_LEN,
    parameter int WAIT_LEN    = DEFAULT_WAIT_LEN,
    parameter int WORD_LEN    = DEFAULT_WORD_LEN,
    parameter int SYNC_STAGES = 2
) (
    input  logic                i_master_clock,
    input  logic                i_rst_n,
    input  logic [WORD_LEN-1:0] data_word_send,
    input  logic                i_SCLK,
    input  logic                i_SS,
    input  logic                i_MOSI,
    output logic                o_MISO,
    output logic                reg_operate,
    output logic                spi_rw,
    output logic                spi_write,
    output logic                spi_read,
    output logic [ADDR_LEN-1:0] spi_addr,
    output logic [WORD_LEN-1:0] spi_data
);

    localparam int FRAME_N = 1 + ADDR_LEN + WAIT_LEN + WORD_LEN;
    localparam int CNT_W   = $clog2(FRAME_N + 1);
    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(ADDR_LEN);
    localparam logic [CNT_W-1:0] WAIT_END  = CNT_W'(1 + ADDR_LEN + WAIT_LEN);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(FRAME_N - 1);

    logic                sclk_rise;
    logic                sclk_fall;
    logic                ss_active;
    logic                mosi_s;
    spi_state_e          state;
    logic [CNT_W-1:0]    bit_cnt;
    logic [ADDR_LEN-1:0] cmd_sr;
    logic [WORD_LEN-1:0] rx_sr;
    logic [WORD_LEN-1:0] miso_sr;
    logic                read_issue;
    logic                done_first;

    spi_slave_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (i_master_clock),
        .rst       (i_rst_n),
        .sclk      (i_SCLK),
        .ss        (i_SS),
        .mosi      (i_MOSI),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .ss_active (ss_active),
        .mosi_s    (mosi_s)
    );

    always_ff @(posedge i_master_clock) begin
        if (i_rst_n) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            cmd_sr      <= '0;
            rx_sr       <= '0;
            miso_sr     <= '0;
            read_issue  <= 1'b0;
            done_first  <= 1'b0;
            o_MISO      <= 1'b0;
            reg_operate <= 1'b0;
            spi_rw      <= 1'b0;
            spi_write   <= 1'b0;
            spi_read    <= 1'b0;
            spi_addr    <= '0;
            spi_data    <= '0;
        end else begin
            spi_write   <= 1'b0;
            spi_read    <= 1'b0;
            reg_operate <= 1'b0;
            // A read strobe issued from the command latch survives an abort.
            if (read_issue) begin
                spi_read    <= 1'b1;
                reg_operate <= 1'b1;
                read_issue  <= 1'b0;
            end
            if (state != ST_IDLE && !ss_active) begin
                state      <= ST_IDLE;
                bit_cnt    <= '0;
                miso_sr    <= '0;
                o_MISO     <= 1'b0;
                done_first <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        bit_cnt <= '0;
                        miso_sr <= '0;
                        o_MISO  <= 1'b0;
                        if (ss_active) state <= ST_CMD;
                    end
                    ST_CMD: begin
                        if (sclk_rise) begin
                            cmd_sr  <= {cmd_sr[ADDR_LEN-2:0], mosi_s};
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == CMD_LAST) begin
                                spi_rw     <= cmd_sr[ADDR_LEN-1];
                                spi_addr   <= {cmd_sr[ADDR_LEN-2:0], mosi_s};
                                read_issue <= cmd_sr[ADDR_LEN-1];
                                state      <= ST_WAIT;
                            end
                        end
                    end
                    ST_WAIT: begin
                        if (sclk_rise) begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end else if (sclk_fall && bit_cnt == WAIT_END) begin
                            if (spi_rw) begin
                                miso_sr <= data_word_send;
                                o_MISO  <= data_word_send[WORD_LEN-1];
                            end
                            state <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (sclk_rise) begin
                            rx_sr   <= {rx_sr[WORD_LEN-2:0], mosi_s};
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == DATA_LAST) begin
                                state      <= ST_DONE;
                                done_first <= 1'b1;
                                miso_sr    <= '0;
                                o_MISO     <= 1'b0;
                            end
                        end else if (sclk_fall && spi_rw) begin
                            o_MISO  <= miso_sr[WORD_LEN-2];
                            miso_sr <= {miso_sr[WORD_LEN-2:0], 1'b0};
                        end
                    end
                    ST_DONE: begin
                        if (done_first) begin
                            done_first <= 1'b0;
                            spi_data   <= rx_sr;
                            if (!spi_rw) begin
                                spi_write   <= 1'b1;
                                reg_operate <= 1'b1;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_top.sv
// Directed bench for spi_slave_top: drives SPI frames as a mode-0 master and
// scores the register strobes against an expected queue.
module tb_spi_slave_top;
    import spi_slave_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] data_word_send = '0;
    logic        sclk = 1'b0;
    logic        ss = 1'b1;
    logic        mosi = 1'b0;
    logic        o_miso;
    logic        reg_operate;
    logic        spi_rw;
    logic        spi_write;
    logic        spi_read;
    logic [7:0]  spi_addr;
    logic [15:0] spi_data;

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;
    int last_rise_cyc = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    logic [24:0] exp_q[$];

    spi_slave_top dut (
        .i_master_clock (clk),
        .i_rst_n        (rst),
        .data_word_send (data_word_send),
        .i_SCLK         (sclk),
        .i_SS           (ss),
        .i_MOSI         (mosi),
        .o_MISO         (o_miso),
        .reg_operate    (reg_operate),
        .spi_rw         (spi_rw),
        .spi_write      (spi_write),
        .spi_read       (spi_read),
        .spi_addr       (spi_addr),
        .spi_data       (spi_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Scoreboard: every strobe must match the next expected {rw, addr, data}.
    always @(negedge clk) begin
        if (!rst && (spi_write || spi_read || reg_operate)) begin
            logic [24:0] got;
            chk("reg_operate with strobe", reg_operate, 1);
            chk("one strobe kind", spi_write & spi_read, 0);
            got = spi_read ? {1'b1, spi_addr, 16'h0000} : {1'b0, spi_addr, spi_data};
            if (spi_write) begin
                wr_cnt++;
                chk("write latency", cyc - last_rise_cyc, 4);
            end
            if (spi_read) rd_cnt++;
            if (exp_q.size() == 0) chk("unexpected strobe", got, 0);
            else chk("strobe content", got, exp_q.pop_front());
        end
    end

    task automatic send_frame(input logic rw, input logic [7:0] addr, input logic [15:0] data,
                              input int nbits, output logic [15:0] rx_word, output int cmd_ones);
        logic [26:0] f;
        f = {rw, addr, 2'b00, data};
        rx_word = '0;
        cmd_ones = 0;
        @(negedge clk) ss = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            mosi = f[26-i];
            repeat (8) @(negedge clk);
            if (i >= 11) rx_word = {rx_word[14:0], o_miso};
            else if (o_miso !== 1'b0) cmd_ones++;
            sclk = 1'b1;
            last_rise_cyc = cyc;
            repeat (8) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (4) @(negedge clk);
        ss = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    logic [15:0] rx_word;
    int          cmd_ones;
    int          miso_err;
    int          wr_before;
    int          rd_before;

    initial begin
        // Reset held for 4 clocks while SCLK toggles with SS low.
        ss = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            sclk = ~sclk;
        end
        chk("reset spi_write", spi_write, 0);
        chk("reset spi_read", spi_read, 0);
        chk("reset reg_operate", reg_operate, 0);
        chk("reset spi_rw", spi_rw, 0);
        chk("reset spi_addr", spi_addr, 0);
        chk("reset spi_data", spi_data, 0);
        chk("reset o_MISO", o_miso, 0);
        ss = 1'b1;
        sclk = 1'b0;
        rst = 1'b0;
        repeat (8) @(negedge clk);

        // Single write frame.
        exp_q.push_back({1'b0, 8'h84, 16'h0000});
        send_frame(1'b0, 8'h84, 16'h0000, 27, rx_word, cmd_ones);
        chk("wr spi_rw", spi_rw, 0);
        chk("wr spi_addr", spi_addr, 8'h84);
        chk("wr spi_data", spi_data, 16'h0000);
        chk("wr write count", wr_cnt, 1);
        chk("wr read count", rd_cnt, 0);
        chk("wr miso quiet", rx_word, 0);

        // Single read frame.
        data_word_send = 16'hFFF5;
        exp_q.push_back({1'b1, 8'h82, 16'h0000});
        send_frame(1'b1, 8'h82, 16'h0000, 27, rx_word, cmd_ones);
        chk("rd miso word", rx_word, 16'hFFF5);
        chk("rd miso zero in cmd/wait", cmd_ones, 0);
        chk("rd spi_rw", spi_rw, 1);
        chk("rd spi_addr", spi_addr, 8'h82);
        chk("rd read count", rd_cnt, 1);
        chk("rd write count", wr_cnt, 1);
        chk("rd miso idle after", o_miso, 0);

        // Back-to-back mixed sequence.
        data_word_send = 16'hFFF3;
        exp_q.push_back({1'b0, 8'h84, 16'h0000});
        send_frame(1'b0, 8'h84, 16'h0000, 27, rx_word, cmd_ones);
        data_word_send = 16'hFFF4;
        exp_q.push_back({1'b0, 8'h83, 16'h0001});
        send_frame(1'b0, 8'h83, 16'h0001, 27, rx_word, cmd_ones);
        chk("b2b spi_data", spi_data, 16'h0001);
        data_word_send = 16'hFFF5;
        exp_q.push_back({1'b1, 8'h82, 16'h0000});
        send_frame(1'b1, 8'h82, 16'h0000, 27, rx_word, cmd_ones);
        chk("b2b read 0x82 word", rx_word, 16'hFFF5);
        data_word_send = 16'hFFF6;
        exp_q.push_back({1'b1, 8'h81, 16'h0000});
        send_frame(1'b1, 8'h81, 16'h0000, 27, rx_word, cmd_ones);
        chk("b2b read 0x81 word", rx_word, 16'hFFF6);
        chk("b2b write count", wr_cnt, 3);
        chk("b2b read count", rd_cnt, 3);

        // Abort a write after bit 15.
        wr_before = wr_cnt;
        send_frame(1'b0, 8'h85, 16'h1234, 16, rx_word, cmd_ones);
        repeat (20) @(negedge clk);
        chk("abort no write", wr_cnt, wr_before);
        chk("abort spi_data kept", spi_data, 16'h0000);

        // SCLK noise with SS high.
        wr_before = wr_cnt;
        rd_before = rd_cnt;
        miso_err = 0;
        for (int i = 0; i < 20; i++) begin
            mosi = 1'($urandom_range(0, 1));
            repeat (8) @(negedge clk);
            sclk = ~sclk;
            if (o_miso !== 1'b0) miso_err++;
        end
        sclk = 1'b0;
        repeat (8) @(negedge clk);
        chk("noise no write", wr_cnt, wr_before);
        chk("noise no read", rd_cnt, rd_before);
        chk("noise miso zero", miso_err, 0);

        // Full frame after abort and noise.
        exp_q.push_back({1'b0, 8'h90, 16'hBEEF});
        send_frame(1'b0, 8'h90, 16'hBEEF, 27, rx_word, cmd_ones);
        chk("post-abort spi_addr", spi_addr, 8'h90);
        chk("post-abort spi_data", spi_data, 16'hBEEF);
        chk("post-abort write count", wr_cnt, wr_before + 1);
        chk("expected queue drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_slave_top.md
# spi_slave_top

SPI slave register-access front end. It decodes 27-bit SPI frames from an external master into single-cycle register read and write strobes for the on-chip register file. It also shifts the returned read word back out on MISO. It sits between the chip's SPI pins and the register file, and is clocked entirely by the system clock, oversampling SCLK.

## Interface
Parameters:
- ADDR_LEN, 8: address field width.
- WAIT_LEN, 2: turnaround bits between the address field and the data field.
- WORD_LEN, 16: data field width.
- SYNC_STAGES, 2: synchronizer depth on i_SCLK, i_SS and i_MOSI.

Ports:
- i_master_clock, in, 1: the single system clock. Everything is on its rising edge.
- i_rst_n, in, 1: synchronous reset, active-high. The port name is kept for codebase compatibility; asserted = 1.
- data_word_send, in, WORD_LEN: read data from the register file.
- i_SCLK, in, 1: SPI clock, asynchronous.
- i_SS, in, 1: slave select, active-low, asynchronous.
- i_MOSI, in, 1: master-to-slave data.
- o_MISO, out, 1: slave-to-master data.
- reg_operate, out, 1: one-cycle pulse on every register access, coincident with spi_write or spi_read.
- spi_rw, out, 1: latched frame direction; 1 = read, 0 = write.
- spi_write, out, 1: one-cycle write strobe.
- spi_read, out, 1: one-cycle read strobe.
- spi_addr, out, ADDR_LEN: latched register address.
- spi_data, out, WORD_LEN: received data field.

## Operation
- **SPI mode:** mode 0, MSB first.
  - MOSI is sampled on the SCLK rising edge.
  - MISO is updated on the SCLK falling edge.
- **Frame layout:** FRAME_LEN = 1+ADDR_LEN+WAIT_LEN+WORD_LEN = 27 bits, in this order: {rw, addr[7:0], wait[1:0], data[15:0]}. Bit index n counts from 0 at the first rising edge after SS falls.
- **Synchronization:**
  - Each input passes through SYNC_STAGES flops before use.
  - Edges are detected by comparing the last two synchronized SCLK samples.
  - All processing is qualified by synchronized SS = 0.
- **States:** IDLE, CMD, WAIT, DATA, DONE.
- **IDLE:**
  - Bit counter is 0; MISO shift register is 0.
  - Leave IDLE to CMD when synchronized SS falls.
- **CMD:**
  - Shift 9 bits into the command register.
  - On the rising edge of bit 8, latch spi_rw and spi_addr and go to WAIT.
  - If rw = 1, pulse spi_read and reg_operate for one cycle, one clock after that latch.
- **WAIT:**
  - Ignore the incoming MOSI bits.
  - Read frame: on the SCLK falling edge after bit 10, load data_word_send into the shift register and drive bit 15 on o_MISO.
  - Go to DATA.
- **DATA:**
  - Shift in 16 data bits.
  - Read frame: each subsequent falling edge shifts out the next bit.
  - After the rising edge of bit 26, go to DONE.
- **DONE:**
  - Update spi_data with the received field.
  - If rw = 0, pulse spi_write and reg_operate for one cycle.
  - Ignore further SCLK edges until SS rises, then return to IDLE.
- **o_MISO:** 0 whenever outside a read frame's data phase, including while SS is high. There is no tristate.
- **Abort:** if SS rises before bit 26, return to IDLE.
  - No spi_write pulse.
  - spi_data is unchanged.
  - An already-issued spi_read is not retracted.
- **Held outputs:** spi_rw and spi_addr hold until the next frame's latch.

## Timing
- **Reset values:** all outputs 0, state IDLE. Reset has priority over every other event.
- **Clock ratio:** i_master_clock must be at least 8× the SCLK frequency. The reference system is 16 MHz with SCLK = clock/16.
- **Input-to-action latency:** SYNC_STAGES+1 clocks from a pin edge to the resulting internal action.
- **MISO timing:** o_MISO changes SYNC_STAGES+1 clocks after the SCLK falling edge.
- **Register read latency:** the register file gets at least 1.5 SCLK periods from the spi_read pulse to the data_word_send sampling point.
- **Write strobe latency:** spi_write asserts SYNC_STAGES+2 clocks after the 27th rising SCLK edge.
- **Back-to-back frames:** require SS high for at least SYNC_STAGES+2 clocks between frames.

## Structure
- **Package spi_slave_pkg:**
  - Default ADDR_LEN, WAIT_LEN and WORD_LEN.
  - FRAME_LEN.
  - The state enum.
- **Sub-module spi_slave_sync:**
  - Synchronizer plus edge detector for SCLK, SS and MOSI.
  - Outputs sclk_rise, sclk_fall, ss_active and mosi_s.
- **spi_slave_top:** holds the FSM, bit counter and shift registers.

## Test plan
- **Reset:** hold i_rst_n = 1 for 4 clocks during SCLK activity → all outputs 0 and no strobes.
- **Write frame:** {0, 0x84, 00, 0x0000} → one spi_write + reg_operate pulse; spi_addr = 0x84, spi_data = 0x0000, spi_rw = 0, no spi_read.
- **Read frame:** {1, 0x82, 00, x} with data_word_send = 0xFFF5 → one spi_read pulse with spi_addr = 0x82; master captures low 16 bits = 0xFFF5; o_MISO = 0 during the command and wait bits; no spi_write.
- **Back-to-back mixed sequence:**
  - Frames: write 0x84/0x0000, write 0x83/0x0001, read 0x82, read 0x81, with data_word_send incrementing per frame from 0xFFF3.
  - Exactly one correct strobe per frame.
  - Read data matches the data_word_send value at each read's sampling point.
- **Abort:** SS rises after bit 15 of a write frame → no spi_write; spi_data unchanged; the next full frame decodes correctly.
- **Idle noise:** SCLK toggling while SS is high → no strobes; o_MISO = 0.
